// File: rtl/digit_serial_subtractor.sv
// rtl/digit_serial_subtractor.sv - digit-serial a - b - bin with registered borrow, valid/ready handshakes and signed overflow flag
module digit_serial_subtractor #(
    parameter int N     = 8,
    parameter int DIGIT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic         busy
);

    localparam int NUM_DIGITS = N / DIGIT;
    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);
    localparam logic [31:0] DIGIT_U = DIGIT;
    localparam logic [N-1:0] DIGIT_MASK = N'({DIGIT{1'b1}});

    generate
        if (DIGIT < 1 || DIGIT > N || (N % DIGIT) != 0) begin : g_bad_params
            $error("digit_serial_subtractor: N must be a positive multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          borrow_q, borrow_d;
    logic          bout_q, bout_d, ovf_q, ovf_d, out_valid_q, out_valid_d;

    logic [31:0]      shamt;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic [DIGIT:0]   sub;

    // Current digit slice; the top bit of the D+1-bit difference is the outgoing borrow.
    always_comb begin
        shamt = 32'(cnt_q) * DIGIT_U;
        a_dig = DIGIT'(a_q >> shamt);
        b_dig = DIGIT'(b_q >> shamt);
        sub   = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, borrow_q};
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        diff_d      = diff_q;
        cnt_d       = cnt_q;
        borrow_d    = borrow_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                diff_d   = (diff_q & ~(DIGIT_MASK << shamt)) | (N'(sub[DIGIT-1:0]) << shamt);
                borrow_d = sub[DIGIT];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    bout_d      = sub[DIGIT];
                    ovf_d       = (a_q[N-1] ^ b_q[N-1]) & (diff_d[N-1] ^ a_q[N-1]);
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            cnt_q       <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            cnt_q       <= cnt_d;
            borrow_q    <= borrow_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// tb/tb_digit_serial_subtractor.sv - directed and randomized-handshake bench for digit_serial_subtractor
module tb_digit_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          sel;
    logic        s_in_valid, s_bin, s_out_ready;
    logic [15:0] s_a, s_b;
    int          tests = 0;
    int          fails = 0;

    logic [3:0]  ir, ov, bo, of, by;
    logic [7:0]  d0, d1, d2;
    logic [15:0] d3;

    logic        m_in_ready, m_out_valid, m_bout, m_ovf, m_busy;
    logic [15:0] m_diff;

    digit_serial_subtractor #(.N(8), .DIGIT(2)) u_n8_d2 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid && (sel == 0)), .in_ready(ir[0]),
        .a(s_a[7:0]), .b(s_b[7:0]), .bin(s_bin), .out_valid(ov[0]),
        .out_ready(s_out_ready && (sel == 0)), .diff(d0), .bout(bo[0]), .ovf(of[0]), .busy(by[0]));

    digit_serial_subtractor #(.N(8), .DIGIT(1)) u_n8_d1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid && (sel == 1)), .in_ready(ir[1]),
        .a(s_a[7:0]), .b(s_b[7:0]), .bin(s_bin), .out_valid(ov[1]),
        .out_ready(s_out_ready && (sel == 1)), .diff(d1), .bout(bo[1]), .ovf(of[1]), .busy(by[1]));

    digit_serial_subtractor #(.N(8), .DIGIT(8)) u_n8_d8 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid && (sel == 2)), .in_ready(ir[2]),
        .a(s_a[7:0]), .b(s_b[7:0]), .bin(s_bin), .out_valid(ov[2]),
        .out_ready(s_out_ready && (sel == 2)), .diff(d2), .bout(bo[2]), .ovf(of[2]), .busy(by[2]));

    digit_serial_subtractor #(.N(16), .DIGIT(4)) u_n16_d4 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid && (sel == 3)), .in_ready(ir[3]),
        .a(s_a), .b(s_b), .bin(s_bin), .out_valid(ov[3]),
        .out_ready(s_out_ready && (sel == 3)), .diff(d3), .bout(bo[3]), .ovf(of[3]), .busy(by[3]));

    always_comb begin
        m_in_ready  = ir[sel[1:0]];
        m_out_valid = ov[sel[1:0]];
        m_bout      = bo[sel[1:0]];
        m_ovf       = of[sel[1:0]];
        m_busy      = by[sel[1:0]];
        case (sel)
            0:       m_diff = {8'h00, d0};
            1:       m_diff = {8'h00, d1};
            2:       m_diff = {8'h00, d2};
            default: m_diff = d3;
        endcase
    end

    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bin);
        int t = 0;
        while (!m_in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        s_a = a;
        s_b = b;
        s_bin = bin;
        s_in_valid = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
        s_a = ~a;
        s_b = ~b;
        s_bin = ~bin;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!m_out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!m_out_valid) lat = -1;
    endtask

    task automatic consume();
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        sel = 0;
        rst = 1'b1;
        s_in_valid = 1'b0;
        s_out_ready = 1'b0;
        s_a = '0;
        s_b = '0;
        s_bin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({m_in_ready, m_out_valid, m_busy, m_bout, m_ovf} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_flags: got %b expected 10000 (in_ready,out_valid,busy,bout,ovf)",
                     {m_in_ready, m_out_valid, m_busy, m_bout, m_ovf});
        end
        tests++;
        if (m_diff !== 16'h0000) begin
            fails++;
            $display("FAIL reset_diff: got %h expected 0000", m_diff);
        end
        tests++;
        if (ov !== 4'b0000 || ir !== 4'b1111) begin
            fails++;
            $display("FAIL reset_all_instances: out_valid %b in_ready %b expected 0000 1111", ov, ir);
        end
    endtask

    task automatic test_basic();
        int lat;
        sel = 0;
        start_op(16'h005A, 16'h003C, 1'b0);
        tests++;
        if ({m_busy, m_in_ready} !== 2'b10) begin
            fails++;
            $display("FAIL basic_busy: got busy,in_ready=%b expected 10", {m_busy, m_in_ready});
        end
        wait_valid(lat);
        tests++;
        if (lat != 4) begin
            fails++;
            $display("FAIL basic_latency: got %0d expected 4", lat);
        end
        tests++;
        if ({m_bout, m_ovf, m_diff[7:0]} !== 10'h01E) begin
            fails++;
            $display("FAIL basic_result: got %h expected 01e", {m_bout, m_ovf, m_diff[7:0]});
        end
        consume();
        tests++;
        if ({m_out_valid, m_in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL basic_release: got out_valid,in_ready=%b expected 01", {m_out_valid, m_in_ready});
        end
    endtask

    task automatic test_borrow_ovf();
        logic [7:0] va[6]   = '{8'h00, 8'h10, 8'h80, 8'h7F, 8'hFF, 8'h00};
        logic [7:0] vb[6]   = '{8'h01, 8'h10, 8'h01, 8'hFF, 8'hFF, 8'h00};
        logic       vbin[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [9:0] ve[6]   = '{10'h2FF, 10'h2FF, 10'h17F, 10'h380, 10'h2FF, 10'h000};
        int lat;
        sel = 0;
        for (int i = 0; i < 6; i++) begin
            start_op({8'h00, va[i]}, {8'h00, vb[i]}, vbin[i]);
            wait_valid(lat);
            tests++;
            if (lat != 4 || {m_bout, m_ovf, m_diff[7:0]} !== ve[i]) begin
                fails++;
                $display("FAIL vector_%0d: got latency %0d {bout,ovf,diff}=%h expected latency 4 %h",
                         i, lat, {m_bout, m_ovf, m_diff[7:0]}, ve[i]);
            end
            consume();
        end
    endtask

    task automatic test_hold();
        int lat;
        sel = 0;
        start_op(16'h005A, 16'h003C, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 6; i++) begin
            s_in_valid = i[0];
            s_a = 16'h00F0;
            s_b = 16'h000F;
            tests++;
            if ({m_out_valid, m_in_ready, m_bout, m_ovf, m_diff[7:0]} !== 12'h81E) begin
                fails++;
                $display("FAIL hold_cycle_%0d: got %h expected 81e (out_valid,in_ready,bout,ovf,diff)",
                         i, {m_out_valid, m_in_ready, m_bout, m_ovf, m_diff[7:0]});
            end
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        consume();
        tests++;
        if ({m_out_valid, m_in_ready, m_busy} !== 3'b010) begin
            fails++;
            $display("FAIL hold_release: got out_valid,in_ready,busy=%b expected 010",
                     {m_out_valid, m_in_ready, m_busy});
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        sel = 0;
        start_op(16'h005A, 16'h003C, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({m_out_valid, m_in_ready, m_busy, m_diff[7:0]} !== 11'h200) begin
            fails++;
            $display("FAIL midrun_reset: got %h expected 200 (out_valid,in_ready,busy,diff)",
                     {m_out_valid, m_in_ready, m_busy, m_diff[7:0]});
        end
        repeat (5) @(negedge clk);
        tests++;
        if (m_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL midrun_no_result: got out_valid %b expected 0", m_out_valid);
        end
        start_op(16'h0080, 16'h0001, 1'b0);
        wait_valid(lat);
        tests++;
        if (lat != 4 || {m_bout, m_ovf, m_diff[7:0]} !== 10'h17F) begin
            fails++;
            $display("FAIL midrun_new_op: got latency %0d result %h expected 4 17f",
                     lat, {m_bout, m_ovf, m_diff[7:0]});
        end
        consume();
    endtask

    task automatic test_back_to_back();
        logic [7:0] va[3] = '{8'h5A, 8'h00, 8'h7F};
        logic [7:0] vb[3] = '{8'h3C, 8'h01, 8'hFF};
        logic [9:0] ve[3] = '{10'h01E, 10'h2FF, 10'h380};
        int acc[3] = '{0, 0, 0};
        int i = 0;
        int r = 0;
        int cyc = 0;
        sel = 0;
        s_out_ready = 1'b1;
        while ((i < 3 || r < 3) && cyc < 60) begin
            if (m_out_valid && r < 3) begin
                tests++;
                if ({m_bout, m_ovf, m_diff[7:0]} !== ve[r]) begin
                    fails++;
                    $display("FAIL b2b_result_%0d: got %h expected %h", r, {m_bout, m_ovf, m_diff[7:0]}, ve[r]);
                end
                r++;
            end
            if (m_in_ready && i < 3) begin
                s_a = {8'h00, va[i]};
                s_b = {8'h00, vb[i]};
                s_bin = 1'b0;
                s_in_valid = 1'b1;
                acc[i] = cyc;
                i++;
            end else begin
                s_in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        s_in_valid = 1'b0;
        s_out_ready = 1'b0;
        tests++;
        if (r != 3 || i != 3) begin
            fails++;
            $display("FAIL b2b_count: got %0d accepts %0d results expected 3 3", i, r);
        end
        tests++;
        if (acc[1] - acc[0] != 6 || acc[2] - acc[1] != 6) begin
            fails++;
            $display("FAIL b2b_interval: got %0d,%0d expected 6,6", acc[1] - acc[0], acc[2] - acc[1]);
        end
    endtask

    task automatic test_sweep();
        for (int s = 1; s <= 3; s++) begin
            int n = (s == 3) ? 16 : 8;
            int smin = -(1 << (n - 1));
            int smax = (1 << (n - 1)) - 1;
            logic [15:0] mask = (s == 3) ? 16'hFFFF : 16'h00FF;
            int shown = 0;
            sel = s;
            @(negedge clk);
            for (int op = 0; op < 1000; op++) begin
                logic [15:0] a, b;
                logic        bin, got, exp_bout, exp_ovf, acc;
                logic [16:0] full;
                logic [17:0] got_v, exp_v;
                int          sa, sb, res, t;
                a = 16'($urandom) & mask;
                b = 16'($urandom) & mask;
                bin = 1'($urandom_range(1));
                if (op == 0) begin a = mask; b = 16'h0000; bin = 1'b0; end
                if (op == 1) begin a = 16'h0000; b = mask; bin = 1'b1; end
                full = {1'b0, a} - {1'b0, b} - 17'(bin);
                exp_bout = full[16];
                sa = (n == 16) ? int'($signed(a)) : int'($signed(a[7:0]));
                sb = (n == 16) ? int'($signed(b)) : int'($signed(b[7:0]));
                res = sa - sb - int'(bin);
                exp_ovf = (res < smin) || (res > smax);
                exp_v = {exp_bout, exp_ovf, full[15:0] & mask};
                acc = 1'b0;
                t = 0;
                while (!acc && t < 100) begin
                    s_a = a;
                    s_b = b;
                    s_bin = bin;
                    s_in_valid = ($urandom_range(3) != 0);
                    acc = s_in_valid && m_in_ready;
                    @(negedge clk);
                    t++;
                end
                s_in_valid = 1'b0;
                s_a = ~a;
                got = 1'b0;
                got_v = '0;
                t = 0;
                while (!got && t < 200) begin
                    s_out_ready = 1'($urandom_range(1));
                    if (m_out_valid && s_out_ready) begin
                        got = 1'b1;
                        got_v = {m_bout, m_ovf, m_diff};
                    end
                    @(negedge clk);
                    t++;
                end
                s_out_ready = 1'b0;
                tests++;
                if (!got || got_v !== exp_v) begin
                    fails++;
                    if (shown < 10) begin
                        $display("FAIL sweep_cfg%0d_op%0d: a=%h b=%h bin=%b got %h (seen %b) expected %h",
                                 s, op, a, b, bin, got_v, got, exp_v);
                        shown++;
                    end
                end
            end
        end
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_ovf();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
